serial_alu_seq: RTL and testbench
=================================

Name: serial_alu_seq

Overview:
- Bit-serial sequencer placed directly upstream of the 1-bit ALU slice (the same slice used in the ripple ALU). It also consumes the slice's output.
- It accepts two WIDTH-bit operands and an ALU opcode. It then drives the slice one bit per clock, LSB first, and chains the carry through an internal register.
- It assembles the WIDTH-bit result plus flags and signals completion with a one-cycle done pulse.
- It is used for area-reduced execution paths and for standalone checking of the slice.

Parameters:
- WIDTH, 32, operand/result width and number of serial RUN cycles (>=2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- op  input  3  opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- a  input  WIDTH  operand A. Captured when start is accepted.
- b  input  WIDTH  operand B. Captured when start is accepted.
- busy  output  1  high from the cycle after accept through the DONE cycle.
- done  output  1  one-cycle pulse. Result and flags are valid while it is high and are held afterwards.
- result  output  WIDTH  operation result.
- cout  output  1  carry out of the MSB (ADD/SUB only, else 0).
- overflow  output  1  signed overflow (ADD/SUB only, else 0).
- zero  output  1  result == 0.
- err  output  1  high with done when op is unsupported.
- slice_a  output  1  to slice dataA.
- slice_b  output  1  to slice dataB.
- slice_signal  output  3  to slice Signal.
- slice_cin  output  1  to slice cin.
- slice_out  input  1  from slice dataOut.
- slice_cout  input  1  from slice cout.

Behaviour:
- Reset: state IDLE; all outputs and internal registers are 0 (result, flags, done, busy, err, slice_*).
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with a supported op: latch a, b, op; idx<=0; carry<=1 for SUB/SLT, else 0; go to RUN.
  - start=1 with an unsupported op (011, 100, 101): err<=1, result<=0, go to DONE. No slice activity.
- RUN, bit idx (0..WIDTH-1):
  - slice_a = A[idx], slice_b = B[idx], slice_cin = carry, slice_signal = latched op. All are combinational from registers.
  - Each cycle: result bit idx <= slice_out; carry <= slice_cout.
  - At idx = WIDTH-1:
    - cout <= slice_cout.
    - overflow <= slice_cin ^ slice_cout for ADD/SUB.
    - For SLT: result <= {0..0, slice_out ^ (slice_cin ^ slice_cout)}, with cout and overflow set to 0.
    - Go to DONE.
- Slice inputs outside RUN: slice_a, slice_b and slice_cin are 0; slice_signal holds the last latched op.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in DONE. zero is recomputed from the final result.
- Latency: start accepted at edge T; RUN spans cycles T+1..T+WIDTH; done is high in cycle T+WIDTH+1. Unsupported op: done in cycle T+1.
- A new start is accepted only in IDLE. Starting in the cycle after done is legal, so back-to-back throughput is one op per WIDTH+2 cycles.
- Ignored inputs:
  - start while busy is ignored, and a/b/op changes mid-operation have no effect.
  - start in the DONE cycle is ignored.
- err clears on the next accepted start.
- rst mid-operation: next cycle is IDLE, busy=0, no done pulse, all outputs 0.
- AND/OR: slice_cin=0. Carry-derived flags are forced to 0.
- The verification bench models the slice behaviourally and feeds slice_out/slice_cout back in the same cycle:
  - Slice inputs: invert = (Signal != 010); addend = b ^ invert.
  - Outputs: AND/OR use the raw b; all other codes output the full-adder sum of a, addend and cin.

Test Plan:
- ADD a=0x7FFFFFFF, b=0x00000001, start at T -> done only in cycle T+33. Expected: result 0x80000000, overflow 1, cout 0, zero 0, busy high T+1..T+33.
- SUB a=5, b=5 -> result 0, zero 1, cout 1, overflow 0. Then SUB a=0, b=1 -> result 0xFFFFFFFF, cout 0.
- SLT a=0xFFFFFFFF, b=1 -> result 1. SLT a=0x80000000, b=1 (overflow case) -> result 1. SLT a=1, b=0xFFFFFFFF -> result 0.
- AND a=0xF0F0F0F0, b=0xFF00FF00 -> 0xF000F000. OR of the same operands -> 0xFFF0FFF0. Both with cout=0 and overflow=0.
- Pulse start with different operands at RUN cycle 5 -> ignored, original result returned. rst at RUN cycle 10 -> busy 0 next cycle, all outputs 0, no done. A fresh ADD 3+4 afterwards -> 7.
- op=011 -> done in T+1 with err=1, result 0. The next valid ADD clears err. Back-to-back: start in the cycle after done is accepted.

Source files
------------

// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer driving a 1-bit ALU slice, LSB first, with the carry
// chained through a register; assembles the result and flags, then pulses done.
module serial_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             err,
    output logic             slice_a,
    output logic             slice_b,
    output logic [2:0]       slice_signal,
    output logic             slice_cin,
    input  logic             slice_out,
    input  logic             slice_cout
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic run;
    logic logic_op;
    logic arith_op;
    logic supported;
    logic is_last;

    assign run      = (state_q == S_RUN);
    assign logic_op = (op_q == OP_AND) || (op_q == OP_OR);
    assign arith_op = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign is_last  = (idx_q == IW'(WIDTH - 1));
    assign supported = (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
                       (op == OP_SUB) || (op == OP_SLT);

    assign slice_a      = run & a_q[idx_q];
    assign slice_b      = run & b_q[idx_q];
    assign slice_cin    = run & ~logic_op & carry_q;
    assign slice_signal = op_q;

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
    assign err      = err_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (supported) begin
                        a_d     = a;
                        b_d     = b;
                        op_d    = op;
                        idx_d   = '0;
                        carry_d = (op == OP_SUB) || (op == OP_SLT);
                        err_d   = 1'b0;
                        state_d = S_RUN;
                    end else begin
                        err_d    = 1'b1;
                        result_d = '0;
                        cout_d   = 1'b0;
                        ovf_d    = 1'b0;
                        zero_d   = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end
            S_RUN: begin
                result_d[idx_q] = slice_out;
                carry_d         = slice_cout;
                idx_d           = idx_q + 1'b1;
                if (is_last) begin
                    cout_d = arith_op & slice_cout;
                    ovf_d  = arith_op & (slice_cin ^ slice_cout);
                    // SLT: sign of the difference corrected by overflow
                    if (op_q == OP_SLT) begin
                        result_d = {{(WIDTH-1){1'b0}},
                                    slice_out ^ slice_cin ^ slice_cout};
                    end
                    zero_d  = (result_d == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Randomised bench for serial_alu_seq with a behavioural slice and an
// arithmetic reference model checked every cycle.
module tb_serial_alu_seq;

    localparam int W = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, cout, overflow, zero, err;
    logic [W-1:0] result;
    logic         slice_a, slice_b, slice_cin, slice_out, slice_cout;
    logic [2:0]   slice_signal;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout),
        .overflow(overflow), .zero(zero), .err(err),
        .slice_a(slice_a), .slice_b(slice_b),
        .slice_signal(slice_signal), .slice_cin(slice_cin),
        .slice_out(slice_out), .slice_cout(slice_cout)
    );

    // behavioural 1-bit ALU slice
    logic s_inv, s_add;
    always_comb begin
        s_inv = (slice_signal != 3'b010);
        s_add = slice_b ^ s_inv;
        if (slice_signal == OP_AND)
            slice_out = slice_a & slice_b;
        else if (slice_signal == OP_OR)
            slice_out = slice_a | slice_b;
        else
            slice_out = slice_a ^ s_add ^ slice_cin;
        slice_cout = (slice_a & s_add) | (slice_a & slice_cin) |
                     (s_add & slice_cin);
    end

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         err;
    } exp_t;

    function automatic logic is_sup(input logic [2:0] o);
        return (o == OP_AND) || (o == OP_OR) || (o == OP_ADD) ||
               (o == OP_SUB) || (o == OP_SLT);
    endfunction

    function automatic exp_t ref_op(input logic [2:0] o,
                                    input logic [W-1:0] x,
                                    input logic [W-1:0] y);
        exp_t e;
        logic [W:0] s;
        e = '0;
        s = '0;
        case (o)
            OP_AND: e.res = x & y;
            OP_OR:  e.res = x | y;
            OP_ADD: begin
                s = {1'b0, x} + {1'b0, y};
                e.res  = s[W-1:0];
                e.cout = s[W];
                e.ovf  = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
            end
            OP_SUB: begin
                s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
                e.res  = s[W-1:0];
                e.cout = s[W];
                e.ovf  = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
            end
            OP_SLT: e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            default: e.err = 1'b1;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // reference timeline: rem counts cycles left until idle
    int         rem;
    exp_t       pend, held;
    logic [2:0] last_op;
    logic       en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            rem     <= 0;
            held    <= '0;
            last_op <= 3'b000;
        end else if (rem == 0) begin
            if (start) begin
                if (is_sup(op)) begin
                    rem      <= W + 1;
                    pend     <= ref_op(op, a, b);
                    last_op  <= op;
                    held.err <= 1'b0;
                end else begin
                    rem  <= 1;
                    held <= ref_op(op, a, b);
                end
            end
        end else begin
            rem <= rem - 1;
            if (rem == 2) held <= pend;
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("busy", 64'(busy), 64'(rem > 0));
            chk("done", 64'(done), 64'(rem == 1));
            chk("slice_signal", 64'(slice_signal), 64'(last_op));
            if (rem <= 1) begin
                chk("result", 64'(result), 64'(held.res));
                chk("cout", 64'(cout), 64'(held.cout));
                chk("overflow", 64'(overflow), 64'(held.ovf));
                chk("zero", 64'(zero), 64'(held.zero));
                chk("err", 64'(err), 64'(held.err));
                chk("idle_slice", 64'({slice_a, slice_b, slice_cin}), 64'(0));
            end else begin
                chk("run_err", 64'(err), 64'(0));
                if (last_op == OP_AND || last_op == OP_OR)
                    chk("logic_cin", 64'(slice_cin), 64'(0));
            end
        end
    end

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < W + 8) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL timeout: no done after %0d cycles", lat);
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, output int lat);
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom);
        a = $urandom;
        b = $urandom;
        wait_done(lat);
    endtask

    int lat;
    int ndone;
    logic [2:0] ro;
    logic [W-1:0] rx, ry;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        op = 3'b000;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        chk("rst_out", 64'({busy, done, cout, overflow, zero, err}), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_slice", 64'({slice_a, slice_b, slice_cin, slice_signal}),
            64'(0));
        rst = 1'b0;
        en = 1'b1;

        run_op(OP_ADD, 32'h7FFFFFFF, 32'h1, lat);
        chk("add_lat", 64'(lat), 64'(W + 1));
        chk("add_res", 64'(result), 64'h80000000);
        chk("add_flags", 64'({cout, overflow, zero}), 64'b010);

        run_op(OP_SUB, 32'd5, 32'd5, lat);
        chk("sub0_res", 64'(result), 64'(0));
        chk("sub0_flags", 64'({cout, overflow, zero}), 64'b101);
        run_op(OP_SUB, 32'd0, 32'd1, lat);
        chk("sub1_res", 64'(result), 64'hFFFFFFFF);
        chk("sub1_cout", 64'(cout), 64'(0));

        run_op(OP_SLT, 32'hFFFFFFFF, 32'd1, lat);
        chk("slt_neg", 64'(result), 64'(1));
        run_op(OP_SLT, 32'h80000000, 32'd1, lat);
        chk("slt_ovf", 64'(result), 64'(1));
        chk("slt_flags", 64'({cout, overflow}), 64'(0));
        run_op(OP_SLT, 32'd1, 32'hFFFFFFFF, lat);
        chk("slt_pos", 64'(result), 64'(0));

        run_op(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, lat);
        chk("and_res", 64'(result), 64'hF000F000);
        chk("and_flags", 64'({cout, overflow}), 64'(0));
        run_op(OP_OR, 32'hF0F0F0F0, 32'hFF00FF00, lat);
        chk("or_res", 64'(result), 64'hFFF0FFF0);
        chk("or_flags", 64'({cout, overflow}), 64'(0));

        // start pulsed during RUN cycle 5 must be ignored
        @(negedge clk);
        start = 1'b1; op = OP_ADD; a = 32'd100; b = 32'd23;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = OP_OR; a = 32'hFFFF0000; b = 32'h0000FFFF;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("ignore_start", 64'(result), 64'd123);

        // reset during RUN cycle 10
        @(negedge clk);
        start = 1'b1; op = OP_SUB; a = 32'hDEADBEEF; b = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_out", 64'({done, cout, overflow, zero, err, result}),
            64'(0));
        ndone = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst_no_done", 64'(ndone), 64'(0));
        run_op(OP_ADD, 32'd3, 32'd4, lat);
        chk("add_after_rst", 64'(result), 64'd7);

        run_op(3'b011, 32'd9, 32'd9, lat);
        chk("err_lat", 64'(lat), 64'(1));
        chk("err_flag", 64'({err, result}), {31'd0, 1'b1, 32'd0});
        run_op(OP_ADD, 32'd1, 32'd1, lat);
        chk("b2b_lat", 64'(lat), 64'(W + 1));
        chk("b2b_res", 64'({err, result}), 64'd2);

        for (int i = 0; i < 50; i++) begin
            ro = 3'($urandom);
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 3))
                0: rx = 32'h80000000;
                1: ry = rx;
                2: ry = 32'hFFFFFFFF;
                default: ;
            endcase
            run_op(ro, rx, ry, lat);
            chk("rand_lat", 64'(lat), is_sup(ro) ? 64'(W + 1) : 64'(1));
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
